msp430_dbg_mem_seq: RTL and testbench
=====================================

Name: msp430_dbg_mem_seq

Overview:
- Debug-side memory access sequencer sitting directly upstream of the memory decoder/backbone.
- Turns single or burst read/write commands from the debug register file into one-cycle memory strobes: dbg_mem_en, dbg_mem_wr, dbg_mem_addr, dbg_mem_dout.
- Captures the returned dbg_mem_din one cycle later and handles byte lane steering and address auto-increment.
- Accesses are only issued while the CPU is halted.

Parameters:
- CNT_W, 16, width of the burst count, and of the internal remaining-access counter.

Ports:
- mclk  in  1  main system clock
- puc_rst  in  1  main system reset
- cmd_start  in  1  one-cycle pulse that launches a command
- cmd_wr  in  1  1 = write, 0 = read
- cmd_byte  in  1  1 = byte access, 0 = word access
- cmd_addr  in  16  start byte address
- cmd_cnt  in  CNT_W  number of accesses minus one (0 = single access)
- wdata  in  16  write data for the current access
- wdata_valid  in  1  wdata holds the next burst write word
- dbg_halt_st  in  1  CPU halted status
- dbg_mem_din  in  16  memory read data, valid one cycle after dbg_mem_en
- dbg_mem_addr  out  16  byte address to memory
- dbg_mem_en  out  1  memory enable, one-cycle pulse per access
- dbg_mem_wr  out  2  byte write enables {hi, lo}
- dbg_mem_dout  out  16  write data to memory
- rd_data  out  16  captured read data
- rd_valid  out  1  one-cycle pulse when rd_data updates
- wdata_ready  out  1  sequencer is waiting for wdata_valid
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command end
- err  out  1  sticky error, cleared on the next accepted cmd_start

Behaviour:
- Clocking and reset:
  - Single clock mclk; reset puc_rst is asynchronous, active-high.
  - All outputs and state reset to 0; FSM resets to IDLE.
  - Reset mid-burst aborts immediately, with no done pulse.
- FSM states: IDLE, ACCESS, CAPTURE, WAIT_WD.
- IDLE:
  - cmd_start with dbg_halt_st=1 latches addr, cmd_cnt, mode and wdata; clears err; sets busy; next state ACCESS.
  - cmd_start with dbg_halt_st=0 sets err and pulses done next cycle; busy stays 0.
  - cmd_start while busy=1 is ignored.
- ACCESS (exactly one cycle):
  - dbg_mem_en=1 and dbg_mem_addr = current address.
  - Writes:
    - word: dbg_mem_wr = 2'b11, dbg_mem_dout = wdata.
    - byte: dbg_mem_wr = addr[0] ? 2'b10 : 2'b01, dbg_mem_dout = {wdata[7:0], wdata[7:0]}.
  - Reads: dbg_mem_wr = 2'b00.
  - Outside ACCESS: dbg_mem_en=0, dbg_mem_wr=0; dbg_mem_addr and dbg_mem_dout hold their last values.
  - Next state: CAPTURE.
- CAPTURE:
  - Read word: rd_data = dbg_mem_din.
  - Read byte: rd_data = {8'h00, addr[0] ? dbg_mem_din[15:8] : dbg_mem_din[7:0]}.
  - rd_valid pulses for reads only.
  - Address advances by 2 (word) or 1 (byte), modulo 2^16 (0xFFFE+2 = 0x0000, 0xFFFF+1 = 0x0000).
  - If the remaining count is 0, or dbg_halt_st=0: go to IDLE, pulse done, clear busy. The halt case also sets err.
  - Otherwise decrement the count; reads go to ACCESS, writes go to WAIT_WD.
- WAIT_WD:
  - wdata_ready=1.
  - wdata_valid latches wdata and moves to ACCESS in the next cycle.
  - dbg_halt_st falling here aborts: done pulses and err is set.
- Throughput: one access per two cycles for reads; writes add the wdata wait.
- Latency: cmd_start at cycle T gives dbg_mem_en at T+1 and rd_valid at T+2.
- Simultaneous events: a halt drop in the same cycle as the last CAPTURE still completes that access, then sets err.

Test Plan:
- Halted, read word at 0x0200, cnt=0, memory returns 0xBEEF → en at T+1 with addr 0x0200 and wr 00; rd_data=0xBEEF with rd_valid at T+2; done at T+2.
- Byte write 0x5A to 0x0201 → dbg_mem_wr=2'b10 and dbg_mem_dout=0x5A5A for exactly one cycle.
- Word read burst at 0xFFFC, cnt=2 → addresses 0xFFFC, 0xFFFE, 0x0000 with en spaced two cycles apart; three rd_valid pulses; one done.
- Write burst cnt=1 with wdata_valid delayed 3 cycles → wdata_ready high for 3 cycles; second en carries the new data; done after the second access.
- cmd_start with dbg_halt_st=0 → no dbg_mem_en; err=1; done pulses.
- Halt drops mid read burst (cnt=5) → current access captured, err=1, done, no further en; puc_rst mid-burst → all outputs 0 immediately.

Source files
------------

// File: rtl/msp430_dbg_mem_seq.sv
// -----------------------------------------------------------------------------
// msp430_dbg_mem_seq
// Debug-side memory access sequencer. Converts single or burst read/write
// commands from the debug register file into one-cycle memory strobes, captures
// the returned read data one cycle later, steers byte lanes and auto-increments
// the address. Accesses are only issued while the CPU is halted.
//
// Ports:
//   i_mclk, i_puc_rst          clock, asynchronous active-high reset
//   i_cmd_start                one-cycle command launch pulse
//   i_cmd_wr / i_cmd_byte      1 = write / 1 = byte access
//   i_cmd_addr                 start byte address
//   i_cmd_cnt                  number of accesses minus one
//   i_wdata, i_wdata_valid     write data and its handshake for burst words
//   i_dbg_halt_st              CPU halted status
//   i_dbg_mem_din              memory read data, valid one cycle after enable
//   o_dbg_mem_addr/en/wr/dout  memory strobes
//   o_rd_data, o_rd_valid      captured read data and its update pulse
//   o_wdata_ready              waiting for the next burst write word
//   o_busy, o_done, o_err      status: in progress, end pulse, sticky error
// -----------------------------------------------------------------------------
module msp430_dbg_mem_seq #(
   parameter int CNT_W = 16
) (
   input  logic             i_mclk,
   input  logic             i_puc_rst,
   input  logic             i_cmd_start,
   input  logic             i_cmd_wr,
   input  logic             i_cmd_byte,
   input  logic [15:0]      i_cmd_addr,
   input  logic [CNT_W-1:0] i_cmd_cnt,
   input  logic [15:0]      i_wdata,
   input  logic             i_wdata_valid,
   input  logic             i_dbg_halt_st,
   input  logic [15:0]      i_dbg_mem_din,
   output logic [15:0]      o_dbg_mem_addr,
   output logic             o_dbg_mem_en,
   output logic [1:0]       o_dbg_mem_wr,
   output logic [15:0]      o_dbg_mem_dout,
   output logic [15:0]      o_rd_data,
   output logic             o_rd_valid,
   output logic             o_wdata_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACCESS  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_WAIT_WD = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [15:0]      r_addr;
   logic [CNT_W-1:0] r_cnt;
   logic             r_wr_mode;
   logic             r_byte_mode;
   logic             r_mem_en;
   logic [1:0]       r_mem_wr;
   logic [15:0]      r_mem_addr;
   logic [15:0]      r_mem_dout;
   logic [15:0]      r_rd_data;
   logic             r_rd_valid;
   logic             r_wdata_ready;
   logic             r_busy;
   logic             r_done_evt;
   logic             r_err;

   logic             w_accept;
   logic             w_reject;
   logic             w_cap_end;
   logic             w_wd_abort;
   logic [15:0]      w_issue_addr;
   logic [15:0]      w_addr_inc;
   logic             w_wr_mode;
   logic             w_byte_mode;
   logic [15:0]      w_rd_steer;

   // Next address: +1 for byte, +2 for word, wrapping at 16 bits.
   assign w_addr_inc  = r_addr + (r_byte_mode ? 16'd1 : 16'd2);
   // Mode of the access about to be issued (fresh command or current burst).
   assign w_wr_mode   = w_accept ? i_cmd_wr   : r_wr_mode;
   assign w_byte_mode = w_accept ? i_cmd_byte : r_byte_mode;
   // Byte reads return the addressed lane zero-extended.
   assign w_rd_steer  = r_byte_mode ?
                        {8'h00, (r_addr[0] ? i_dbg_mem_din[15:8] : i_dbg_mem_din[7:0])} :
                        i_dbg_mem_din;

   // Next-state and event decode for the access sequencer.
   always_comb begin
      w_state_nxt  = r_state;
      w_accept     = 1'b0;
      w_reject     = 1'b0;
      w_cap_end    = 1'b0;
      w_wd_abort   = 1'b0;
      w_issue_addr = r_addr;
      case (r_state)
         ST_IDLE: begin
            if (i_cmd_start && i_dbg_halt_st) begin
               w_accept     = 1'b1;
               w_issue_addr = i_cmd_addr;
               w_state_nxt  = ST_ACCESS;
            end else if (i_cmd_start) begin
               w_reject     = 1'b1;
            end else begin
               w_state_nxt  = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            w_state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            // The access in flight always completes; only then is halt checked.
            if ((r_cnt == '0) || !i_dbg_halt_st) begin
               w_cap_end   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (r_wr_mode) begin
               w_state_nxt = ST_WAIT_WD;
            end else begin
               w_issue_addr = w_addr_inc;
               w_state_nxt  = ST_ACCESS;
            end
         end
         ST_WAIT_WD: begin
            if (!i_dbg_halt_st) begin
               w_wd_abort  = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (i_wdata_valid) begin
               w_state_nxt = ST_ACCESS;
            end else begin
               w_state_nxt = ST_WAIT_WD;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, command context and registered memory/status outputs.
   always_ff @(posedge i_mclk or posedge i_puc_rst) begin
      if (i_puc_rst) begin
         r_state       <= ST_IDLE;
         r_addr        <= 16'h0000;
         r_cnt         <= '0;
         r_wr_mode     <= 1'b0;
         r_byte_mode   <= 1'b0;
         r_mem_en      <= 1'b0;
         r_mem_wr      <= 2'b00;
         r_mem_addr    <= 16'h0000;
         r_mem_dout    <= 16'h0000;
         r_rd_data     <= 16'h0000;
         r_rd_valid    <= 1'b0;
         r_wdata_ready <= 1'b0;
         r_busy        <= 1'b0;
         r_done_evt    <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_mem_en      <= (w_state_nxt == ST_ACCESS);
         r_rd_valid    <= (w_state_nxt == ST_CAPTURE) && !r_wr_mode;
         r_wdata_ready <= (w_state_nxt == ST_WAIT_WD);
         r_busy        <= (w_state_nxt != ST_IDLE);
         // Late done for rejects and write-wait aborts; CAPTURE ends signal directly.
         r_done_evt    <= w_reject || w_wd_abort;

         // Strobes are loaded on entry to ACCESS; address/data then hold.
         if (w_state_nxt == ST_ACCESS) begin
            r_mem_addr <= w_issue_addr;
            if (w_wr_mode) begin
               if (w_byte_mode) begin
                  r_mem_wr   <= w_issue_addr[0] ? 2'b10 : 2'b01;
                  r_mem_dout <= {i_wdata[7:0], i_wdata[7:0]};
               end else begin
                  r_mem_wr   <= 2'b11;
                  r_mem_dout <= i_wdata;
               end
            end else begin
               r_mem_wr <= 2'b00;
            end
         end else begin
            r_mem_wr <= 2'b00;
         end

         if ((r_state == ST_CAPTURE) && !r_wr_mode) begin
            r_rd_data <= w_rd_steer;
         end

         if (w_accept) begin
            r_addr      <= i_cmd_addr;
            r_cnt       <= i_cmd_cnt;
            r_wr_mode   <= i_cmd_wr;
            r_byte_mode <= i_cmd_byte;
         end else if ((r_state == ST_CAPTURE) && !w_cap_end) begin
            r_addr <= w_addr_inc;
            r_cnt  <= r_cnt - CNT_W'(1);
         end

         if (w_accept) begin
            r_err <= 1'b0;
         end else if (w_reject || w_wd_abort || (w_cap_end && !i_dbg_halt_st)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign o_dbg_mem_addr = r_mem_addr;
   assign o_dbg_mem_en   = r_mem_en;
   assign o_dbg_mem_wr   = r_mem_wr;
   assign o_dbg_mem_dout = r_mem_dout;
   // Read data is visible in the CAPTURE cycle itself, then held.
   assign o_rd_data      = r_rd_valid ? w_rd_steer : r_rd_data;
   assign o_rd_valid     = r_rd_valid;
   assign o_wdata_ready  = r_wdata_ready;
   assign o_busy         = r_busy;
   assign o_done         = r_done_evt || w_cap_end;
   assign o_err          = r_err;

endmodule

// File: tb/tb_msp430_dbg_mem_seq.sv
module tb_msp430_dbg_mem_seq;

   logic        clk;
   logic        rst;
   logic        cmd_start;
   logic        cmd_wr;
   logic        cmd_byte;
   logic [15:0] cmd_addr;
   logic [15:0] cmd_cnt;
   logic [15:0] wdata;
   logic        wdata_valid;
   logic        halt;
   logic [15:0] din;
   logic [15:0] mem_addr;
   logic        mem_en;
   logic [1:0]  mem_wr;
   logic [15:0] mem_dout;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        wdata_ready;
   logic        busy;
   logic        done;
   logic        err;

   logic [15:0] key;
   int          n_checks;
   int          n_errors;

   msp430_dbg_mem_seq #(.CNT_W(16)) dut (
      .i_mclk        (clk),
      .i_puc_rst     (rst),
      .i_cmd_start   (cmd_start),
      .i_cmd_wr      (cmd_wr),
      .i_cmd_byte    (cmd_byte),
      .i_cmd_addr    (cmd_addr),
      .i_cmd_cnt     (cmd_cnt),
      .i_wdata       (wdata),
      .i_wdata_valid (wdata_valid),
      .i_dbg_halt_st (halt),
      .i_dbg_mem_din (din),
      .o_dbg_mem_addr(mem_addr),
      .o_dbg_mem_en  (mem_en),
      .o_dbg_mem_wr  (mem_wr),
      .o_dbg_mem_dout(mem_dout),
      .o_rd_data     (rd_data),
      .o_rd_valid    (rd_valid),
      .o_wdata_ready (wdata_ready),
      .o_busy        (busy),
      .o_done        (done),
      .o_err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory: read data = address XOR key, one cycle after enable.
   always @(posedge clk) begin
      if (mem_en && (mem_wr == 2'b00)) din <= mem_addr ^ key;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_strobe(input string tag);
      chk({tag, "_en"}, {31'd0, mem_en}, 32'd0);
      chk({tag, "_wr"}, {30'd0, mem_wr}, 32'd0);
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      rst = 1'b1; cmd_start = 1'b0; cmd_wr = 1'b0; cmd_byte = 1'b0;
      cmd_addr = 16'h0000; cmd_cnt = 16'd0; wdata = 16'h0000;
      wdata_valid = 1'b0; halt = 1'b1; din = 16'h0000; key = 16'h0000;
      tick(); tick();
      // Reset state
      chk("rst_en", {31'd0, mem_en}, 32'd0);
      chk("rst_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_ready", {31'd0, wdata_ready}, 32'd0);
      rst = 1'b0;
      tick();

      // 1: single word read at 0x0200, memory returns 0xBEEF
      key = 16'hBCEF;
      cmd_start = 1'b1; cmd_wr = 1'b0; cmd_byte = 1'b0; cmd_addr = 16'h0200; cmd_cnt = 16'd0;
      tick(); cmd_start = 1'b0;
      chk("r1_en", {31'd0, mem_en}, 32'd1);
      chk("r1_addr", {16'd0, mem_addr}, 32'h0200);
      chk("r1_wr", {30'd0, mem_wr}, 32'd0);
      chk("r1_busy", {31'd0, busy}, 32'd1);
      chk("r1_done_early", {31'd0, done}, 32'd0);
      tick();
      chk("r1_rdv", {31'd0, rd_valid}, 32'd1);
      chk("r1_rdata", {16'd0, rd_data}, 32'hBEEF);
      chk("r1_done", {31'd0, done}, 32'd1);
      chk("r1_en_off", {31'd0, mem_en}, 32'd0);
      tick();
      chk("r1_done_off", {31'd0, done}, 32'd0);
      chk("r1_rdv_off", {31'd0, rd_valid}, 32'd0);
      chk("r1_hold", {16'd0, rd_data}, 32'hBEEF);
      chk("r1_idle", {31'd0, busy}, 32'd0);

      // 2: byte write 0x5A to 0x0201 (upper wdata byte must be ignored)
      cmd_start = 1'b1; cmd_wr = 1'b1; cmd_byte = 1'b1; cmd_addr = 16'h0201; wdata = 16'h125A;
      tick(); cmd_start = 1'b0;
      chk("bw_en", {31'd0, mem_en}, 32'd1);
      chk("bw_wr", {30'd0, mem_wr}, 32'h2);
      chk("bw_dout", {16'd0, mem_dout}, 32'h5A5A);
      chk("bw_addr", {16'd0, mem_addr}, 32'h0201);
      tick();
      chk_idle_strobe("bw_after");
      chk("bw_dout_hold", {16'd0, mem_dout}, 32'h5A5A);
      chk("bw_rdv", {31'd0, rd_valid}, 32'd0);
      chk("bw_done", {31'd0, done}, 32'd1);
      tick();
      chk("bw_done_off", {31'd0, done}, 32'd0);

      // 3: word read burst wrapping through 0xFFFF
      key = 16'h1234;
      cmd_start = 1'b1; cmd_wr = 1'b0; cmd_byte = 1'b0; cmd_addr = 16'hFFFC; cmd_cnt = 16'd2;
      tick(); cmd_start = 1'b0;
      chk("rb_a0", {16'd0, mem_addr}, 32'hFFFC);
      chk("rb_en0", {31'd0, mem_en}, 32'd1);
      tick();
      chk("rb_d0", {16'd0, rd_data}, 32'hEDC8);
      chk("rb_v0", {31'd0, rd_valid}, 32'd1);
      chk("rb_done0", {31'd0, done}, 32'd0);
      chk("rb_gap0", {31'd0, mem_en}, 32'd0);
      tick();
      chk("rb_a1", {16'd0, mem_addr}, 32'hFFFE);
      chk("rb_en1", {31'd0, mem_en}, 32'd1);
      tick();
      chk("rb_d1", {16'd0, rd_data}, 32'hEDCA);
      chk("rb_done1", {31'd0, done}, 32'd0);
      tick();
      chk("rb_a2", {16'd0, mem_addr}, 32'h0000);
      chk("rb_en2", {31'd0, mem_en}, 32'd1);
      tick();
      chk("rb_d2", {16'd0, rd_data}, 32'h1234);
      chk("rb_v2", {31'd0, rd_valid}, 32'd1);
      chk("rb_done2", {31'd0, done}, 32'd1);
      tick();
      chk("rb_busy_end", {31'd0, busy}, 32'd0);
      chk("rb_en_end", {31'd0, mem_en}, 32'd0);

      // 4: word write burst, second word delayed; a start while busy is ignored
      cmd_start = 1'b1; cmd_wr = 1'b1; cmd_byte = 1'b0; cmd_addr = 16'h0300; cmd_cnt = 16'd1;
      wdata = 16'h1111;
      tick(); cmd_start = 1'b0;
      chk("wb_wr0", {30'd0, mem_wr}, 32'h3);
      chk("wb_dout0", {16'd0, mem_dout}, 32'h1111);
      tick();
      chk("wb_ready_cap", {31'd0, wdata_ready}, 32'd0);
      chk("wb_done_cap", {31'd0, done}, 32'd0);
      tick();
      chk("wb_ready1", {31'd0, wdata_ready}, 32'd1);
      chk("wb_en_wait", {31'd0, mem_en}, 32'd0);
      cmd_start = 1'b1; cmd_addr = 16'h0400; wdata = 16'h9999;
      tick(); cmd_start = 1'b0;
      chk("wb_ready2", {31'd0, wdata_ready}, 32'd1);
      chk("wb_ignored", {31'd0, mem_en}, 32'd0);
      tick();
      chk("wb_ready3", {31'd0, wdata_ready}, 32'd1);
      wdata = 16'h2222; wdata_valid = 1'b1;
      tick(); wdata_valid = 1'b0;
      chk("wb_ready_off", {31'd0, wdata_ready}, 32'd0);
      chk("wb_en1", {31'd0, mem_en}, 32'd1);
      chk("wb_addr1", {16'd0, mem_addr}, 32'h0302);
      chk("wb_dout1", {16'd0, mem_dout}, 32'h2222);
      tick();
      chk("wb_done", {31'd0, done}, 32'd1);
      tick();
      chk("wb_busy_end", {31'd0, busy}, 32'd0);

      // 5: start while running -> rejected
      halt = 1'b0;
      cmd_start = 1'b1; cmd_wr = 1'b0; cmd_addr = 16'h0500; cmd_cnt = 16'd0;
      tick(); cmd_start = 1'b0;
      chk("nh_en", {31'd0, mem_en}, 32'd0);
      chk("nh_busy", {31'd0, busy}, 32'd0);
      chk("nh_err", {31'd0, err}, 32'd1);
      chk("nh_done", {31'd0, done}, 32'd1);
      tick();
      chk("nh_done_off", {31'd0, done}, 32'd0);
      chk("nh_err_sticky", {31'd0, err}, 32'd1);
      chk("nh_en2", {31'd0, mem_en}, 32'd0);
      halt = 1'b1;

      // 6: halt drops mid read burst
      key = 16'h0000;
      cmd_start = 1'b1; cmd_wr = 1'b0; cmd_byte = 1'b0; cmd_addr = 16'h0100; cmd_cnt = 16'd5;
      tick(); cmd_start = 1'b0;
      chk("hd_err_clr", {31'd0, err}, 32'd0);
      tick();
      chk("hd_d0", {16'd0, rd_data}, 32'h0100);
      tick();
      chk("hd_a1", {16'd0, mem_addr}, 32'h0102);
      halt = 1'b0;
      tick();
      chk("hd_v1", {31'd0, rd_valid}, 32'd1);
      chk("hd_d1", {16'd0, rd_data}, 32'h0102);
      chk("hd_done", {31'd0, done}, 32'd1);
      tick();
      chk("hd_err", {31'd0, err}, 32'd1);
      chk("hd_no_en", {31'd0, mem_en}, 32'd0);
      chk("hd_busy", {31'd0, busy}, 32'd0);
      chk("hd_done_off", {31'd0, done}, 32'd0);
      tick();
      chk("hd_no_en2", {31'd0, mem_en}, 32'd0);
      halt = 1'b1;

      // 7: byte read of high lane with halt dropping on the last access
      key = 16'h3400;
      cmd_start = 1'b1; cmd_wr = 1'b0; cmd_byte = 1'b1; cmd_addr = 16'h0201; cmd_cnt = 16'd0;
      tick(); cmd_start = 1'b0;
      halt = 1'b0;
      tick();
      chk("lb_rdv", {31'd0, rd_valid}, 32'd1);
      chk("lb_data", {16'd0, rd_data}, 32'h0036);
      chk("lb_done", {31'd0, done}, 32'd1);
      tick();
      chk("lb_err", {31'd0, err}, 32'd1);
      halt = 1'b1;

      // 8: reset mid-burst clears everything immediately
      key = 16'hBCEF;
      cmd_start = 1'b1; cmd_wr = 1'b0; cmd_byte = 1'b0; cmd_addr = 16'h0200; cmd_cnt = 16'd5;
      tick(); cmd_start = 1'b0;
      tick();
      chk("pr_rdv", {31'd0, rd_valid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("pr_en", {31'd0, mem_en}, 32'd0);
      chk("pr_addr", {16'd0, mem_addr}, 32'd0);
      chk("pr_dout", {16'd0, mem_dout}, 32'd0);
      chk("pr_rdata", {16'd0, rd_data}, 32'd0);
      chk("pr_rdv0", {31'd0, rd_valid}, 32'd0);
      chk("pr_busy", {31'd0, busy}, 32'd0);
      chk("pr_done", {31'd0, done}, 32'd0);
      chk("pr_err", {31'd0, err}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("pr_after_en", {31'd0, mem_en}, 32'd0);
      chk("pr_after_done", {31'd0, done}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
